// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_timing_pkg : standard raster mode tables and shared types               |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
package vga_timing_pkg;

   typedef struct packed {
      int h_visible;
      int h_front;
      int h_sync;
      int h_back;
      int v_visible;
      int v_front;
      int v_sync;
      int v_back;
      bit h_sync_pol;
      bit v_sync_pol;
   } vga_mode_t;

   localparam vga_mode_t MODE_1024X768_60 = '{
      h_visible: 1024, h_front: 24, h_sync: 136, h_back: 160,
      v_visible: 768,  v_front: 3,  v_sync: 6,   v_back: 29,
      h_sync_pol: 1'b0, v_sync_pol: 1'b0
   };

   localparam vga_mode_t MODE_800X600_60 = '{
      h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
      v_visible: 600, v_front: 1,  v_sync: 4,   v_back: 23,
      h_sync_pol: 1'b1, v_sync_pol: 1'b1
   };

   localparam vga_mode_t MODE_640X480_60 = '{
      h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
      v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33,
      h_sync_pol: 1'b0, v_sync_pol: 1'b0
   };

   // Raster state carried down the latency pipeline.
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
   } vga_ctl_t;

   // Never returns less than 1 so a degenerate range still yields a legal width.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result++;
         rem = rem >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_timing_gen_if : pixel request and display output bundle                 |
// | Revision          : 1.0                                                     |
// +-----------------------------------------------------------------------------+
interface vga_timing_gen_if #(
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int COLOR_W = 8
);
   logic [3*COLOR_W-1:0] color_in;
   logic                 req_active;
   logic [X_W-1:0]       req_x;
   logic [Y_W-1:0]       req_y;
   logic                 line_start;
   logic                 frame_start;
   logic                 hsync;
   logic                 vsync;
   logic                 de;
   logic [COLOR_W-1:0]   red;
   logic [COLOR_W-1:0]   green;
   logic [COLOR_W-1:0]   blue;

   modport master (
      input  color_in,
      output req_active, req_x, req_y, line_start, frame_start,
      output hsync, vsync, de, red, green, blue
   );

   modport slave (
      output color_in,
      input  req_active, req_x, req_y, line_start, frame_start,
      input  hsync, vsync, de, red, green, blue
   );
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_axis_counter : one raster axis (visible, front, sync, back)             |
// | Revision         : 1.0                                                      |
// +-----------------------------------------------------------------------------+
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = 8,
   parameter int FRONT   = 1,
   parameter int SYNC    = 1,
   parameter int BACK    = 1,
   localparam int TOTAL  = VISIBLE + FRONT + SYNC + BACK,
   localparam int CNT_W  = clog2(TOTAL)
)(
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             step,
   output logic [CNT_W-1:0]      cnt,
   output logic                  wrap,
   output logic                  visible,
   output logic                  sync_region
);

   localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] C_VISIBLE    = CNT_W'(VISIBLE);
   localparam logic [CNT_W-1:0] C_SYNC_START = CNT_W'(VISIBLE + FRONT);
   localparam logic [CNT_W-1:0] C_SYNC_END   = CNT_W'(VISIBLE + FRONT + SYNC);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             last;

   always_comb begin
      last  = (cnt_q == C_LAST);
      cnt_d = cnt_q;
      if (step) begin
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt         = cnt_q;
   assign wrap        = step & last;
   assign visible     = (cnt_q < C_VISIBLE);
   assign sync_region = (cnt_q >= C_SYNC_START) && (cnt_q < C_SYNC_END);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_timing_gen : parametrised raster timing with early pixel requests       |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = MODE_1024X768_60.h_visible,
   parameter int H_FRONT    = MODE_1024X768_60.h_front,
   parameter int H_SYNC     = MODE_1024X768_60.h_sync,
   parameter int H_BACK     = MODE_1024X768_60.h_back,
   parameter int V_VISIBLE  = MODE_1024X768_60.v_visible,
   parameter int V_FRONT    = MODE_1024X768_60.v_front,
   parameter int V_SYNC     = MODE_1024X768_60.v_sync,
   parameter int V_BACK     = MODE_1024X768_60.v_back,
   parameter bit H_SYNC_POL = MODE_1024X768_60.h_sync_pol,
   parameter bit V_SYNC_POL = MODE_1024X768_60.v_sync_pol,
   parameter int LATENCY    = 2,
   parameter int COLOR_W    = 8
)(
   input  wire logic        clk,
   input  wire logic        rst,
   vga_timing_gen_if.master bus
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int X_W     = clog2(H_VISIBLE);
   localparam int Y_W     = clog2(V_VISIBLE);
   localparam int HC_W    = clog2(H_TOTAL);
   localparam int VC_W    = clog2(V_TOTAL);
   localparam logic H_ON  = H_SYNC_POL;
   localparam logic V_ON  = V_SYNC_POL;

   if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
      $error("vga_timing_gen: every timing parameter must be >= 1");
   end
   if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("vga_timing_gen: LATENCY must be within 0..15");
   end

   logic [HC_W-1:0] h_cnt;
   logic [VC_W-1:0] v_cnt;
   logic            h_wrap;
   logic            v_wrap;
   logic            h_vis;
   logic            v_vis;
   logic            h_sync_rgn;
   logic            v_sync_rgn;
   logic            unused_v_wrap;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .clk         (clk),
      .rst         (rst),
      .step        (1'b1),
      .cnt         (h_cnt),
      .wrap        (h_wrap),
      .visible     (h_vis),
      .sync_region (h_sync_rgn)
   );

   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .clk         (clk),
      .rst         (rst),
      .step        (h_wrap),
      .cnt         (v_cnt),
      .wrap        (v_wrap),
      .visible     (v_vis),
      .sync_region (v_sync_rgn)
   );

   assign unused_v_wrap = v_wrap;

   // Request side is purely combinational; reset masks the strobes so the
   // consumer never sees a request from the frame being abandoned.
   logic req_active;
   assign req_active      = ~rst & h_vis & v_vis;
   assign bus.req_active  = req_active;
   assign bus.req_x       = req_active ? h_cnt[X_W-1:0] : '0;
   assign bus.req_y       = req_active ? v_cnt[Y_W-1:0] : '0;
   assign bus.line_start  = ~rst & v_vis & (h_cnt == '0);
   assign bus.frame_start = ~rst & (h_cnt == '0) & (v_cnt == '0);

   vga_ctl_t ctl_now;
   vga_ctl_t ctl_dly;
   assign ctl_now = '{active: req_active, hsync: h_sync_rgn, vsync: v_sync_rgn};

   if (LATENCY == 0) begin : g_no_pipe
      assign ctl_dly = ctl_now;
   end else begin : g_pipe
      vga_ctl_t pipe_q [LATENCY];
      vga_ctl_t pipe_d [LATENCY];

      always_comb begin
         pipe_d[0] = ctl_now;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         for (int i = 0; i < LATENCY; i++) begin
            if (rst) begin
               pipe_q[i] <= '0;
            end else begin
               pipe_q[i] <= pipe_d[i];
            end
         end
      end

      assign ctl_dly = pipe_q[LATENCY-1];
   end

   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;
   logic                 de_q, de_d;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;

   always_comb begin
      de_d    = ctl_dly.active;
      hsync_d = ctl_dly.hsync ? H_ON : ~H_ON;
      vsync_d = ctl_dly.vsync ? V_ON : ~V_ON;
      rgb_d   = ctl_dly.active ? bus.color_in : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q <= ~H_ON;
         vsync_q <= ~V_ON;
         de_q    <= 1'b0;
         rgb_q   <= '0;
      end else begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         rgb_q   <= rgb_d;
      end
   end

   assign bus.hsync = hsync_q;
   assign bus.vsync = vsync_q;
   assign bus.de    = de_q;
   assign bus.red   = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign bus.green = rgb_q[2*COLOR_W-1:COLOR_W];
   assign bus.blue  = rgb_q[COLOR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_vga_timing_gen : small-mode LATENCY=2 and default-mode LATENCY=0 checks  |
// | Revision          : 1.0                                                     |
// +-----------------------------------------------------------------------------+
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_s;
   logic rst_d;

   vga_timing_gen_if #(.X_W(3),  .Y_W(2),  .COLOR_W(8)) bus_s ();
   vga_timing_gen_if #(.X_W(10), .Y_W(10), .COLOR_W(8)) bus_d ();

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
      .LATENCY(2), .COLOR_W(8)
   ) dut_s (
      .clk (clk),
      .rst (rst_s),
      .bus (bus_s)
   );

   vga_timing_gen #(
      .LATENCY(0)
   ) dut_d (
      .clk (clk),
      .rst (rst_d),
      .bus (bus_d)
   );

   int          n_checks;
   int          n_errors;
   int          g;
   logic [23:0] hist [4];

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock, apply resets, then play the fixed-latency colour source.
   task automatic tick(input logic new_rst_s, input logic new_rst_d);
      @(posedge clk);
      #1;
      rst_s = new_rst_s;
      rst_d = new_rst_d;
      #1;
      bus_s.color_in = (g >= 2) ? hist[(g - 2) % 4] : 24'hFFFFFF;
      hist[g % 4]    = bus_s.req_active ?
                       {5'b0, bus_s.req_x, 6'b0, bus_s.req_y, 8'hA5} : 24'hFFFFFF;
      bus_d.color_in = bus_d.req_active ?
                       {bus_d.req_x[7:0], bus_d.req_y[7:0], 8'h3C} : 24'hFFFFFF;
      g++;
      #1;
   endtask

   // Small mode: H_TOTAL 16, V_TOTAL 8, outputs trail requests by 3 clocks.
   task automatic check_small(input int c);
      int   h, v, oh, ov;
      logic act, ode, ohs, ovs;
      h   = c % 16;
      v   = (c / 16) % 8;
      act = (h < 8) && (v < 4);
      check_value("s_req_active", 32'(bus_s.req_active), 32'(act));
      check_value("s_req_x", 32'(bus_s.req_x), act ? 32'(h) : 32'd0);
      check_value("s_req_y", 32'(bus_s.req_y), act ? 32'(v) : 32'd0);
      check_value("s_line_start", 32'(bus_s.line_start), 32'((h == 0) && (v < 4)));
      check_value("s_frame_start", 32'(bus_s.frame_start), 32'((h == 0) && (v == 0)));
      if (c < 3) begin
         ode = 1'b0; ohs = 1'b1; ovs = 1'b1; oh = 0; ov = 0;
      end else begin
         oh  = (c - 3) % 16;
         ov  = ((c - 3) / 16) % 8;
         ode = (oh < 8) && (ov < 4);
         ohs = !((oh >= 10) && (oh < 13));
         ovs = !((ov >= 5) && (ov < 7));
      end
      check_value("s_de", 32'(bus_s.de), 32'(ode));
      check_value("s_hsync", 32'(bus_s.hsync), 32'(ohs));
      check_value("s_vsync", 32'(bus_s.vsync), 32'(ovs));
      check_value("s_red", 32'(bus_s.red), ode ? 32'(oh) : 32'd0);
      check_value("s_green", 32'(bus_s.green), ode ? 32'(ov) : 32'd0);
      check_value("s_blue", 32'(bus_s.blue), ode ? 32'hA5 : 32'd0);
   endtask

   // Default 1024x768 mode with LATENCY 0: outputs trail requests by 1 clock.
   task automatic check_default(input int c);
      int   h, v, oh, ov;
      logic act, ode, ohs;
      h   = c % 1344;
      v   = c / 1344;
      act = (h < 1024);
      check_value("d_req_active", 32'(bus_d.req_active), 32'(act));
      check_value("d_req_x", 32'(bus_d.req_x), act ? 32'(h) : 32'd0);
      check_value("d_req_y", 32'(bus_d.req_y), act ? 32'(v) : 32'd0);
      check_value("d_line_start", 32'(bus_d.line_start), 32'(h == 0));
      check_value("d_frame_start", 32'(bus_d.frame_start), 32'((h == 0) && (v == 0)));
      if (c < 1) begin
         ode = 1'b0; ohs = 1'b1; oh = 0; ov = 0;
      end else begin
         oh  = (c - 1) % 1344;
         ov  = (c - 1) / 1344;
         ode = (oh < 1024);
         ohs = !((oh >= 1048) && (oh < 1184));
      end
      check_value("d_de", 32'(bus_d.de), 32'(ode));
      check_value("d_hsync", 32'(bus_d.hsync), 32'(ohs));
      check_value("d_vsync", 32'(bus_d.vsync), 32'd1);
      check_value("d_red", 32'(bus_d.red), ode ? 32'(oh % 256) : 32'd0);
      check_value("d_green", 32'(bus_d.green), ode ? 32'(ov % 256) : 32'd0);
      check_value("d_blue", 32'(bus_d.blue), ode ? 32'h3C : 32'd0);
   endtask

   initial begin
      int ls_cnt, fs_cnt, hs_low, vs_low, last_ls;
      n_checks = 0;
      n_errors = 0;
      g        = 0;
      ls_cnt   = 0;
      fs_cnt   = 0;
      hs_low   = 0;
      vs_low   = 0;
      last_ls  = -1;
      rst_s    = 1'b1;
      rst_d    = 1'b1;
      bus_s.color_in = 24'hFFFFFF;
      bus_d.color_in = 24'hFFFFFF;
      for (int i = 0; i < 4; i++) hist[i] = 24'hFFFFFF;

      repeat (3) tick(1'b1, 1'b1);

      check_value("rst_s_req_active", 32'(bus_s.req_active), 32'd0);
      check_value("rst_s_line_start", 32'(bus_s.line_start), 32'd0);
      check_value("rst_s_frame_start", 32'(bus_s.frame_start), 32'd0);
      check_value("rst_s_hsync", 32'(bus_s.hsync), 32'd1);
      check_value("rst_s_vsync", 32'(bus_s.vsync), 32'd1);
      check_value("rst_s_de", 32'(bus_s.de), 32'd0);
      check_value("rst_s_rgb", 32'({bus_s.red, bus_s.green, bus_s.blue}), 32'd0);
      check_value("rst_d_req_active", 32'(bus_d.req_active), 32'd0);
      check_value("rst_d_hsync", 32'(bus_d.hsync), 32'd1);
      check_value("rst_d_de", 32'(bus_d.de), 32'd0);

      // Three free-running frames of the small mode.
      for (int c = 0; c < 384; c++) begin
         tick(1'b0, 1'b1);
         check_small(c);
         if (bus_s.line_start)  ls_cnt++;
         if (bus_s.frame_start) fs_cnt++;
         if (!bus_s.hsync)      hs_low++;
         if (!bus_s.vsync)      vs_low++;
      end
      check_value("s_line_start_count", 32'(ls_cnt), 32'd12);
      check_value("s_frame_start_count", 32'(fs_cnt), 32'd3);
      check_value("s_hsync_low_count", 32'(hs_low), 32'd72);
      check_value("s_vsync_low_count", 32'(vs_low), 32'd96);

      // Run up to (h=5, v=2) of the fourth frame, then pulse reset there.
      for (int c = 384; c < 421; c++) begin
         tick(1'b0, 1'b1);
         check_small(c);
      end
      tick(1'b1, 1'b1);
      check_value("midrst_req_active", 32'(bus_s.req_active), 32'd0);
      check_value("midrst_line_start", 32'(bus_s.line_start), 32'd0);
      check_value("midrst_frame_start", 32'(bus_s.frame_start), 32'd0);
      for (int c = 0; c < 160; c++) begin
         tick(1'b0, 1'b1);
         check_small(c);
      end

      // Default mode, LATENCY 0: a few full lines.
      for (int c = 0; c < 1344 * 4 + 8; c++) begin
         tick(1'b1, 1'b0);
         check_default(c);
         if (bus_d.line_start) begin
            if (last_ls >= 0) check_value("d_line_period", 32'(c - last_ls), 32'd1344);
            last_ls = c;
         end
      end
      check_value("d_last_line_start", 32'(last_ls), 32'(1344 * 4));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised, single-clock VGA/DVI raster timing generator; successor to the fixed-mode controller.
- Generates the h/v counters, sync pulses and data-enable, and issues pixel requests (x, y) ahead of time so an external colour source of fixed latency can be aligned.
- Outputs registered RGB that is forced to zero outside the active area.
- Sits between the frame-buffer/pattern logic (request side) and the DAC/encoder pins (output side).

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync width (clocks)
- H_BACK, 160, horizontal back porch (clocks)
- V_VISIBLE, 768, active lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BACK, 29, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level (0 = active-low)
- LATENCY, 2, clocks from req_* to matching color_in (0..15)
- COLOR_W, 8, bits per colour channel
- Derived: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*, X_W = clog2(H_VISIBLE), Y_W = clog2(V_VISIBLE); internal counters are clog2(H_TOTAL) and clog2(V_TOTAL) bits wide.

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- color_in  in  3*COLOR_W  {r,g,b} for the pixel requested LATENCY clocks earlier
- req_active  out  1  current counter position is inside the active area
- req_x  out  X_W  requested column (0 when !req_active)
- req_y  out  Y_W  requested row (0 when !req_active)
- line_start  out  1  1-clk pulse at h=0 of each visible line (request side)
- frame_start  out  1  1-clk pulse at h=0, v=0 (request side)
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- de  out  1  data enable, aligned with red/green/blue
- red, green, blue  out  COLOR_W each  registered pixel colour

Behaviour:
- Line order is visible, front, sync, back. h_cnt counts 0..H_TOTAL-1 every clk and wraps to 0. v_cnt increments when h_cnt = H_TOTAL-1 and wraps after V_TOTAL-1. No derived clocks or edges.
- Active area: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- hsync is asserted for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
- vsync is asserted for V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC. It changes with h_cnt = 0 of the line, so it is line-aligned.
- Request side is combinational from the counters:
  - req_x = h_cnt and req_y = v_cnt when active, otherwise 0.
  - req_active, line_start and frame_start are all forced to 0 while rst = 1.
- Output side: hsync/vsync/de describing counter state at cycle t appear after the edge ending cycle t+LATENCY. Latency is therefore LATENCY+1 clocks, delivered through a LATENCY-deep shift pipeline plus the output register.
- RGB is registered from color_in sampled in cycle t+LATENCY when the delayed active bit is 1; otherwise it registers 0. With LATENCY = 0, color_in is sampled in the same cycle as req_*.
- Reset:
  - h_cnt, v_cnt and all pipeline stages go to 0/inactive.
  - Outputs: hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL, de = 0, rgb = 0.
  - Reset mid-frame abandons the frame immediately. The first cycle after rst deasserts has h_cnt = 0, v_cnt = 0, req_active = 1 and frame_start = 1.
  - The first de = 1 occurs LATENCY+1 clocks after that cycle.
- Wrap-around: frame_start coincides with line_start on line 0. No glitch at the h/v wrap; the last back-porch clock is followed directly by pixel (0,0).
- Elaboration checks: every timing parameter must be >= 1, and LATENCY must be <= 15. Violations are reported with $error.

Decomposition:
- Package vga_timing_pkg:
  - mode constant sets (1024x768@60, 800x600@60, 640x480@60) as localparam groups of the eight timing values plus both polarities;
  - a clog2 helper function.
- One sub-module, vga_axis_counter, instantiated twice (H and V).
  - Parameters: VISIBLE, FRONT, SYNC, BACK.
  - Inputs: clk, rst, step.
  - Outputs: cnt, wrap (combinational, = step & last), visible, sync_region.
  - H instance has step = 1; V instance has step = H wrap.

Test Plan (small mode H = 8/2/3/3 → H_TOTAL 16; V = 4/1/2/1 → V_TOTAL 8; LATENCY = 2; polarities 0):
- Reset release → cycle 0: req_active = 1, req_x = 0, req_y = 0, frame_start = 1. hsync = 1, vsync = 1 and de = 0 until cycle 3, then de = 1.
- Free run, 3 frames → line_start every 16 clks on lines 0..3 only; frame_start every 128 clks; req_x steps 0..7 and is 0 on h = 8..15.
- Sync timing → hsync low for exactly 3 clks, at output cycles h = 13..15 (counter h = 10..12 plus 3). vsync low for 32 clks, on lines 5..6 shifted by 3 clks.
- Colour alignment → color_in = {req_x, req_y, 8'hA5} delayed by 2 clks; each de = 1 cycle shows red = x, green = y in raster order. Drive color_in = FFFFFF during blanking → rgb stays 0 while de = 0.
- Mid-frame reset at v = 2, h = 5 for 1 clk → next cycle frame_start = 1 and req (0,0); outputs inactive for 3 clks; no partial sync pulse.
- LATENCY = 0 variant → de and rgb follow req_active by exactly 1 clk; the default 1024x768 mode shows a line period of 1344 clks and 806 lines per frame (spot-check 2 frames).
